systolic_result_drain: RTL

- Downstream consumer of the PE matrix `result_col` lanes.
- Deskews the diagonal (lane i arrives i cycles after lane 0) column outputs into aligned rows, buffers the rows in a small FIFO, and serialises them into single-element memory writes starting at the C base address.
- Replaces the ad-hoc write path currently inside the controller; sits between the PE matrix and the shared memory port.

---
 rtl/systolic_result_drain_pkg.sv | 21 ++
 rtl/systolic_result_drain_result_row_fifo.sv | 91 +++++++++
 rtl/systolic_result_drain.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared types for the systolic result drain: drain FSM states, the width of
// the matrix-dimension field, and the helper that resolves the active
// dimension requested by the controller.
package systolic_result_drain_pkg;

    // Width of the active-dimension field (the n port and its counters).
    localparam int N_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

    // A requested dimension of 0, or one larger than the array, means "full array".
    function automatic logic [N_W-1:0] effective_n(input logic [N_W-1:0] n_req,
                                                   input logic [N_W-1:0] n_max);
        return ((n_req == '0) || (n_req > n_max)) ? n_max : n_req;
    endfunction

endpackage

// File: rtl/systolic_result_drain_result_row_fifo.sv
// Aligned-row FIFO for the result drain. Holds whole N-lane rows, exposes the
// head row and the row behind it (so the writer can roll straight into the
// next row), and allows push and pop on the same edge even when full.
module result_row_fifo
    import systolic_result_drain_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [N-1:0][WIDTH-1:0]       push_row,
    output logic [N-1:0][WIDTH-1:0]       head_row,
    output logic [N-1:0][WIDTH-1:0]       next_row,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [AW-1:0]             rd_next_ptr;
    logic                      push_ok;
    logic                      pop_ok;
    logic [N-1:0][WIDTH-1:0]   mem_q [DEPTH];

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign push_ok     = push && !clear && (!full || pop);
    assign pop_ok      = pop && !clear && !empty;
    assign rd_next_ptr = rd_ptr_q + AW'(1);
    assign head_row    = mem_q[rd_ptr_q];
    assign next_row    = mem_q[rd_next_ptr];

    // Pointer and occupancy update; a clear empties the FIFO in one edge.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Row storage.
    // NOTE: the storage array is deliberately not reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_row;
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Systolic result drain: deskews the diagonal PE-matrix column outputs into
// aligned rows, queues them in a small row FIFO and serialises the active
// n x n block into single-element memory writes from the latched C base.
// Optional build macro DRAIN_RELU_EN clamps negative elements to zero at the
// write register; addressing and timing are the same either way.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int N          = 4,
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [N_W-1:0]              n,
    input  logic [N-1:0][WIDTH-1:0]     result_col,
    input  logic                        result_valid,
    input  logic                        mem_ready,
    output logic                        mem_write,
    output logic signed [WIDTH-1:0]     mem_data_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int             LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int             CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [N_W-1:0] N_MAX  = N_W'(N);

    drain_state_t              state_q, state_d;
    logic [ADDR_W-1:0]         addr_ptr_q, addr_ptr_d;
    logic [N_W-1:0]            n_eff_q, n_eff_d;
    logic [N_W-1:0]            col_q, col_d;
    logic [N_W-1:0]            row_q, row_d;
    logic [N_W-1:0]            rows_in_q, rows_in_d;
    logic                      mem_write_q, mem_write_d;
    logic [WIDTH-1:0]          data_q, data_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;

    logic [N-2:0]              vld_q, vld_d;
    logic                      valid_in;
    logic                      aligned_valid;
    logic [N-1:0][WIDTH-1:0]   aligned_row;

    logic                      fifo_clear;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [N-1:0][WIDTH-1:0]   head_row;
    logic [N-1:0][WIDTH-1:0]   next_row;

    logic                      fire;
    logic [N_W-1:0]            last_idx;
    logic [N_W-1:0]            col_next;
    logic [ADDR_W-1:0]         addr_next;

    // Element transform applied on the way into the write data register.
    function automatic logic [WIDTH-1:0] drain_elem(input logic [WIDTH-1:0] x);
`ifdef DRAIN_RELU_EN
        return x[WIDTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Rows that start outside a running job never enter the deskew pipeline.
    assign valid_in      = result_valid && (state_q == RUN);
    assign aligned_valid = vld_q[N-2];

    // Lane N-1 arrives last, so it joins the aligned row straight from the input.
    assign aligned_row[N-1] = result_col[N-1];

    for (genvar i = 0; i < N - 1; i++) begin : g_skew
        localparam int STAGES = N - 1 - i;
        logic [STAGES-1:0][WIDTH-1:0] stg_q, stg_d;

        // Shift lane i through its N-1-i delay stages.
        always_comb begin
            stg_d[0] = result_col[i];
            for (int s = 1; s < STAGES; s++) begin
                stg_d[s] = stg_q[s-1];
            end
        end

        // Lane i delay registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stg_q <= '0;
            end else begin
                stg_q <= stg_d;
            end
        end

        assign aligned_row[i] = stg_q[STAGES-1];
    end

    // Delay the lane-0 valid by N-1 stages so it lines up with the full row.
    always_comb begin
        vld_d[0] = valid_in;
        for (int s = 1; s < N - 1; s++) begin
            vld_d[s] = vld_q[s-1];
        end
    end

    // Valid delay registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    result_row_fifo #(
        .N     (N),
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (fifo_clear),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .push_row (aligned_row),
        .head_row (head_row),
        .next_row (next_row),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign fire      = mem_write_q && mem_ready;
    assign last_idx  = n_eff_q - N_W'(1);
    assign col_next  = col_q + N_W'(1);
    assign addr_next = addr_ptr_q + ADDR_W'(1);

    // Drain FSM: job start, element sequencing, row acceptance and overflow.
    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        n_eff_d     = n_eff_q;
        col_d       = col_q;
        row_d       = row_q;
        rows_in_d   = rows_in_q;
        mem_write_d = mem_write_q;
        data_d      = data_q;
        addr_d      = addr_q;
        overflow_d  = overflow_q;
        fifo_clear  = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_ptr_d = base_addr;
                    n_eff_d    = effective_n(n, N_MAX);
                    col_d      = '0;
                    row_d      = '0;
                    rows_in_d  = '0;
                    overflow_d = 1'b0;
                    fifo_clear = 1'b1;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (fire) begin
                    addr_ptr_d = addr_next;
                    if (col_q == last_idx) begin
                        // Row finished: retire it and roll into the next one if it is already queued.
                        fifo_pop = 1'b1;
                        col_d    = '0;
                        if (row_q == last_idx) begin
                            mem_write_d = 1'b0;
                            state_d     = DONE;
                        end else begin
                            row_d = row_q + N_W'(1);
                            if (fifo_count >= CNT_W'(2)) begin
                                mem_write_d = 1'b1;
                                data_d      = drain_elem(next_row[0]);
                                addr_d      = addr_next;
                            end else begin
                                mem_write_d = 1'b0;
                            end
                        end
                    end else begin
                        col_d       = col_next;
                        mem_write_d = 1'b1;
                        data_d      = drain_elem(head_row[col_next[LANE_W-1:0]]);
                        addr_d      = addr_next;
                    end
                end else if (!mem_write_q && !fifo_empty) begin
                    mem_write_d = 1'b1;
                    data_d      = drain_elem(head_row[col_q[LANE_W-1:0]]);
                    addr_d      = addr_ptr_q;
                end

                // A row meeting a full FIFO is flagged even if it would have been surplus;
                // otherwise only the first n_eff rows of the job are kept.
                if (aligned_valid) begin
                    if (fifo_full && !fifo_pop) begin
                        overflow_d = 1'b1;
                    end else if (rows_in_q < n_eff_q) begin
                        fifo_push = 1'b1;
                        rows_in_d = rows_in_q + N_W'(1);
                    end
                end
            end

            DONE: begin
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Drain FSM and write-port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_ptr_q  <= '0;
            n_eff_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rows_in_q   <= '0;
            mem_write_q <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            n_eff_q     <= n_eff_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rows_in_q   <= rows_in_d;
            mem_write_q <= mem_write_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_write      = mem_write_q;
    assign mem_data_write = data_q;
    assign mem_addr       = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule
